seg7_scan_driver: RTL and testbench

- Multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Holds a double-buffered value. Scans digit enables at a parametrised rate. Decodes each nibble to active-low segments, with optional hex, decimal points, per-digit blanking, leading-zero suppression and anti-ghosting guard time.
- Sits between the value-producing logic (counters, measurement blocks) and the board pins.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_scan_driver_if.sv | 13 +
 rtl/seg7_hex_decode.sv | 16 +
 rtl/seg7_scan_driver.sv | 78 +++++++
 tb/tb_seg7_scan_driver.sv | 137 +++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes and bit positions for an active-low 7-segment display
package seg7_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;
  localparam logic [7:0] SEG_CODE [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value/control inputs and pin outputs of the scan driver
interface seg7_scan_driver_if #(parameter int DIGITS = 4);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  frame;
  modport master (output en, load, value, dp, blank, input seg, an, frame);
  modport slave  (input en, load, value, dp, blank, output seg, an, frame);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low segment byte with dp and blanking
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_hex_en,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);
  logic [7:0] w_code;
  always_comb begin
    w_code = (i_nib > 4'd9 && !i_hex_en) ? SEG_OFF : SEG_CODE[i_nib];
    o_seg  = i_blank ? SEG_OFF : w_code & ~(8'(i_dp) << SEG_DP);
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered multiplexed 7-segment scanner with guard time
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int GUARD       = 2,
  parameter int HEX_EN      = 1,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  seg7_scan_driver_if.slave    io_bus
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int BW = 6 * DIGITS;
  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_pend, r_act;
  logic [7:0]            r_seg;
  logic [DIGITS-1:0]     r_an;
  logic                  r_frame;
  logic [BW-1:0]         w_new;
  logic [4*DIGITS-1:0]   w_val;
  logic [DIGITS-1:0]     w_dp, w_blk, w_sup;
  logic                  w_z, w_slot_end, w_last, w_wrap, w_dark;
  logic [7:0]            w_dig;
  assign w_new      = {io_bus.value, io_bus.dp, io_bus.blank};
  assign w_val      = r_act[BW-1:2*DIGITS];
  assign w_dp       = r_act[2*DIGITS-1:DIGITS];
  assign w_blk      = r_act[DIGITS-1:0];
  assign w_slot_end = r_pre == PW'(SCAN_DIV - 1);
  assign w_last     = r_idx == IW'(DIGITS - 1);
  assign w_wrap     = io_bus.en && w_slot_end && w_last;
  assign w_dark     = !io_bus.en || int'(r_pre) < GUARD;
  // Suppression ripples down from the top digit; BLANK deliberately does not break it
  always_comb begin
    w_sup = '0;
    w_z   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_z      = w_z & (w_val[4*k +: 4] == 4'd0) & ~w_dp[k];
      w_sup[k] = (LZ_SUPPRESS != 0) && (k != 0) && w_z;
    end
  end
  seg7_hex_decode u_dec (
    .i_nib    (w_val[4*r_idx +: 4]),
    .i_hex_en (HEX_EN != 0),
    .i_dp     (w_dp[r_idx]),
    .i_blank  (w_blk[r_idx] | w_sup[r_idx]),
    .o_seg    (w_dig)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_pend  <= '0;
      r_act   <= '0;
      r_seg   <= SEG_OFF;
      r_an    <= '1;
      r_frame <= 1'b0;
    end else begin
      if (io_bus.load) r_pend <= w_new;
      if (!io_bus.en) r_act <= r_pend;
      else if (w_wrap) r_act <= io_bus.load ? w_new : r_pend;
      if (io_bus.en) begin
        r_pre <= w_slot_end ? '0 : r_pre + 1'b1;
        if (w_slot_end) r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      r_seg   <= w_dark ? SEG_OFF : w_dig;
      r_an    <= w_dark ? '1 : ~(DIGITS'(1) << r_idx);
      r_frame <= w_wrap;
    end
  end
  assign io_bus.seg   = r_seg;
  assign io_bus.an    = r_an;
  assign io_bus.frame = r_frame;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed plus random stimulus against a cycle-level display model
module tb_seg7_scan_driver;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int G  = 1;
  logic clk = 0, rst_n = 0, en = 0, load = 0;
  logic [15:0] value = 0;
  logic [3:0]  dp = 0, blank = 0;
  int tests = 0, fails = 0;
  int m_pre, m_idx;
  logic [15:0] pv, av;
  logic [3:0]  pdp, pbl, adp, abl;
  logic [7:0]  tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                           8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  always #5 clk = ~clk;
  seg7_scan_driver_if #(.DIGITS(D)) bus_a ();
  seg7_scan_driver_if #(.DIGITS(D)) bus_b ();
  assign bus_a.en = en;
  assign bus_a.load = load;
  assign bus_a.value = value;
  assign bus_a.dp = dp;
  assign bus_a.blank = blank;
  assign bus_b.en = en;
  assign bus_b.load = load;
  assign bus_b.value = value;
  assign bus_b.dp = dp;
  assign bus_b.blank = blank;
  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G), .HEX_EN(1), .LZ_SUPPRESS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_a));
  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G), .HEX_EN(0), .LZ_SUPPRESS(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_b));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] dec(input int k, input bit hex);
    logic [3:0] n;
    logic [7:0] c;
    bit sup;
    n = av[4*k +: 4];
    c = (n > 9 && !hex) ? 8'hFF : tab[n];
    if (adp[k]) c[0] = 1'b0;
    sup = (k != 0);
    for (int j = k; j < D; j++) if (av[4*j +: 4] != 0 || adp[j]) sup = 0;
    if (abl[k] || sup) c = 8'hFF;
    return c;
  endfunction
  task automatic rst_model();
    m_pre = 0; m_idx = 0;
    pv = 0; pdp = 0; pbl = 0; av = 0; adp = 0; abl = 0;
  endtask
  task automatic cyc();
    logic [7:0] ea, eb;
    logic [3:0] ean;
    logic ef;
    bit lit;
    @(posedge clk);
    ea = 8'hFF; eb = 8'hFF; ean = 4'hF; ef = 0;
    if (rst_n) begin
      lit = en && m_pre >= G;
      if (lit) begin
        ea = dec(m_idx, 1);
        eb = dec(m_idx, 0);
        ean = ~(4'b1 << m_idx);
      end
      ef = en && m_pre == SD - 1 && m_idx == D - 1;
      if (!en) {av, adp, abl} = {pv, pdp, pbl};
      else if (ef) {av, adp, abl} = load ? {value, dp, blank} : {pv, pdp, pbl};
      if (load) {pv, pdp, pbl} = {value, dp, blank};
      if (en) begin
        if (m_pre == SD - 1) begin
          m_pre = 0;
          m_idx = (m_idx + 1) % D;
        end else m_pre++;
      end
    end
    #1;
    chk("seg_hex", bus_a.seg, ea);
    chk("seg_nohex", bus_b.seg, eb);
    chk("an_hex", {4'h0, bus_a.an}, {4'h0, ean});
    chk("an_nohex", {4'h0, bus_b.an}, {4'h0, ean});
    chk("frame_hex", {7'h0, bus_a.frame}, {7'h0, ef});
    chk("frame_nohex", {7'h0, bus_b.frame}, {7'h0, ef});
  endtask
  task automatic ld(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1;
    cyc();
    load = 0;
  endtask
  initial begin
    rst_model();
    repeat (3) cyc();
    rst_n = 1; en = 1;
    repeat (40) cyc();
    repeat (5) cyc();
    ld(16'h12AF, 4'b0100, 4'b0000);
    repeat (40) cyc();
    ld(16'h00B7, 4'b0000, 4'b0000);
    repeat (36) cyc();
    ld(16'h0050, 4'b0100, 4'b0000);
    repeat (36) cyc();
    ld(16'h3000, 4'b0000, 4'b1000);
    repeat (36) cyc();
    repeat (6) cyc();
    en = 0;
    repeat (4) cyc();
    ld(16'h9876, 4'b0001, 4'b0000);
    repeat (5) cyc();
    en = 1;
    repeat (24) cyc();
    repeat (400) begin
      en = $urandom_range(0, 15) != 0;
      load = $urandom_range(0, 7) == 0;
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
      blank = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
      cyc();
    end
    load = 0; en = 1;
    ld(16'h0042, 4'b0000, 4'b0000);
    repeat (21) cyc();
    #3 rst_n = 0;
    #1;
    chk("async_seg", bus_a.seg, 8'hFF);
    chk("async_an", {4'h0, bus_a.an}, 8'h0F);
    chk("async_frame", {7'h0, bus_a.frame}, 8'h00);
    rst_model();
    repeat (2) cyc();
    #3 rst_n = 1;
    repeat (24) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
